// File: rtl/mem_stage_sram_ctrl_pkg.sv
// Shared constants and state encoding for the memory stage
// and its 16-bit SRAM controller.
package mem_stage_sram_ctrl_pkg;

  localparam int REGISTER_LEN = 32;
  localparam int ADDRESS_LEN = 32;
  localparam int SRAM_DATA_LEN = 16;
  localparam int DATA_MEM_BASE_DEF = 1024;
  localparam int SRAM_ADDR_LEN_DEF = 18;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOW  = 2'd1,
    HIGH = 2'd2,
    DONE = 2'd3
  } mem_state_e;

  function automatic logic [ADDRESS_LEN-1:0] word_index(
    input logic [ADDRESS_LEN-1:0] addr,
    input logic [ADDRESS_LEN-1:0] base
  );
    return (addr - base) >> 2;
  endfunction

endpackage

// File: rtl/mem_stage_sram_ctrl_wait_counter.sv
// Wait-state counter for one 16-bit SRAM half access;
// terminal flags the last cycle of the half.
module sram_wait_counter #(
  parameter int WAIT_CYCLES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic terminal
);

  logic [3:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= cnt + 4'd1;
    end
  end

  assign terminal = (cnt == 4'(WAIT_CYCLES - 1));

endmodule

// File: rtl/mem_stage_sram_ctrl.sv
// Memory stage: splits each 32-bit access into two
// wait-stated 16-bit SRAM halves and freezes the pipeline.
module mem_stage_sram_ctrl
  import mem_stage_sram_ctrl_pkg::*;
#(
  parameter int WAIT_CYCLES = 2,
  parameter int DATA_MEM_BASE = DATA_MEM_BASE_DEF,
  parameter int SRAM_ADDR_LEN = SRAM_ADDR_LEN_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wb_enable_in,
  input  logic                     mem_read_in,
  input  logic                     mem_write_in,
  input  logic [REGISTER_LEN-1:0]  alu_res_in,
  input  logic [REGISTER_LEN-1:0]  val_rm_in,
  input  logic [3:0]               dest_in,
  output logic                     wb_enable_out,
  output logic                     mem_read_out,
  output logic [3:0]               dest_out,
  output logic [REGISTER_LEN-1:0]  alu_res_out,
  output logic [REGISTER_LEN-1:0]  mem_data_out,
  output logic                     freeze,
  output logic [SRAM_ADDR_LEN-1:0] sram_addr,
  output logic [SRAM_DATA_LEN-1:0] sram_dq_out,
  input  logic [SRAM_DATA_LEN-1:0] sram_dq_in,
  output logic                     sram_we_n,
  output logic                     sram_oe_n
);

  mem_state_e state, state_n;
  logic busy;
  logic term;
  logic is_load;
  logic [SRAM_ADDR_LEN-2:0] word;

  assign wb_enable_out = wb_enable_in;
  assign mem_read_out = mem_read_in;
  assign dest_out = dest_in;
  assign alu_res_out = alu_res_in;

  assign busy = (state == LOW) || (state == HIGH);
  assign is_load = mem_read_in && !mem_write_in;
  assign freeze = (mem_read_in | mem_write_in)
                  & (state != DONE);

  // Addresses below the base wrap modulo 2^32.
  assign word = (SRAM_ADDR_LEN-1)'(
    word_index(alu_res_in, ADDRESS_LEN'(DATA_MEM_BASE)));

  sram_wait_counter #(
    .WAIT_CYCLES(WAIT_CYCLES)
  ) u_cnt (
    .clk     (clk),
    .rst     (rst),
    .clear   (!busy || term),
    .enable  (busy),
    .terminal(term)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: if (mem_read_in || mem_write_in) state_n = LOW;
      LOW:  if (term) state_n = HIGH;
      HIGH: if (term) state_n = DONE;
      DONE: state_n = IDLE;
    endcase
  end

  always_comb begin
    sram_addr = '0;
    sram_dq_out = '0;
    sram_we_n = 1'b1;
    sram_oe_n = 1'b1;
    if (busy) begin
      sram_addr = {word, state == HIGH};
      if (mem_write_in) begin
        sram_we_n = 1'b0;
        sram_dq_out = (state == HIGH) ?
          val_rm_in[31:16] : val_rm_in[15:0];
      end else if (mem_read_in) begin
        sram_oe_n = 1'b0;
      end
    end
  end

  // Each half is captured on the last wait cycle of its phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_data_out <= '0;
    end else if (busy && term && is_load) begin
      if (state == LOW) begin
        mem_data_out[15:0] <= sram_dq_in;
      end else begin
        mem_data_out[31:16] <= sram_dq_in;
      end
    end
  end

endmodule

// File: tb/tb_mem_stage_sram_ctrl.sv
// Directed scoreboard bench for mem_stage_sram_ctrl with
// WAIT_CYCLES=2 and WAIT_CYCLES=1 instances and SRAM models.
module tb_mem_stage_sram_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  logic wb_en;
  logic [3:0] dest;
  logic [31:0] alu, val;
  logic rd1, wr1, rd2, wr2;

  logic wb_o1, mr_o1, fr1, we1, oe1;
  logic [3:0] dest_o1;
  logic [31:0] alu_o1, md1;
  logic [17:0] addr1;
  logic [15:0] dqo1, dqi1;

  logic wb_o2, mr_o2, fr2, we2, oe2;
  logic [3:0] dest_o2;
  logic [31:0] alu_o2, md2;
  logic [17:0] addr2;
  logic [15:0] dqo2, dqi2;

  logic [15:0] mem1 [64];
  logic [15:0] mem2 [64];
  logic [15:0] shadow1 [64];
  logic [31:0] md_model [3];

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        fr;
    logic [17:0] addr;
    logic [15:0] dq;
    logic        we;
    logic        oe;
    logic        chk_md;
    logic [31:0] md;
  } exp_t;

  exp_t q[$];

  mem_stage_sram_ctrl #(.WAIT_CYCLES(2)) dut1 (
    .clk(clk), .rst(rst),
    .wb_enable_in(wb_en), .mem_read_in(rd1),
    .mem_write_in(wr1), .alu_res_in(alu),
    .val_rm_in(val), .dest_in(dest),
    .wb_enable_out(wb_o1), .mem_read_out(mr_o1),
    .dest_out(dest_o1), .alu_res_out(alu_o1),
    .mem_data_out(md1), .freeze(fr1),
    .sram_addr(addr1), .sram_dq_out(dqo1),
    .sram_dq_in(dqi1), .sram_we_n(we1),
    .sram_oe_n(oe1)
  );

  mem_stage_sram_ctrl #(.WAIT_CYCLES(1)) dut2 (
    .clk(clk), .rst(rst),
    .wb_enable_in(wb_en), .mem_read_in(rd2),
    .mem_write_in(wr2), .alu_res_in(alu),
    .val_rm_in(val), .dest_in(dest),
    .wb_enable_out(wb_o2), .mem_read_out(mr_o2),
    .dest_out(dest_o2), .alu_res_out(alu_o2),
    .mem_data_out(md2), .freeze(fr2),
    .sram_addr(addr2), .sram_dq_out(dqo2),
    .sram_dq_in(dqi2), .sram_we_n(we2),
    .sram_oe_n(oe2)
  );

  assign dqi1 = mem1[addr1[5:0]];
  assign dqi2 = mem2[addr2[5:0]];

  always @(posedge clk) begin
    if (!we1) mem1[addr1[5:0]] <= dqo1;
    if (!we2) mem2[addr2[5:0]] <= dqo2;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h",
             tag, obs, exp);
    end
  endtask

  task automatic push(input logic fr,
                      input logic [17:0] a,
                      input logic [15:0] d,
                      input logic we, input logic oe,
                      input logic cm,
                      input logic [31:0] md);
    exp_t e;
    e = '{fr, a, d, we, oe, cm, md};
    q.push_back(e);
  endtask

  task automatic run_access(input int sel,
                            input string tag,
                            input logic rd,
                            input logic wr,
                            input logic [31:0] a,
                            input logic [31:0] v,
                            input bit skip_idle);
    int w;
    logic [31:0] wd;
    logic [17:0] lo, hi;
    logic rdo;
    exp_t e;
    logic o_fr, o_we, o_oe;
    logic [17:0] o_a;
    logic [15:0] o_d;
    logic [31:0] o_md;
    w = (sel == 1) ? 2 : 1;
    alu = a;
    val = v;
    if (sel == 1) begin
      rd1 = rd; wr1 = wr;
    end else begin
      rd2 = rd; wr2 = wr;
    end
    wd = (a - 32'd1024) >> 2;
    lo = {wd[16:0], 1'b0};
    hi = {wd[16:0], 1'b1};
    rdo = rd && !wr;
    if (!skip_idle) push(1, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < w; i++)
      push(1, lo, wr ? v[15:0] : 16'h0, !wr, !rdo, 0, 0);
    for (int i = 0; i < w; i++)
      push(1, hi, wr ? v[31:16] : 16'h0, !wr, !rdo, 0, 0);
    if (wr && sel == 1) begin
      shadow1[lo[5:0]] = v[15:0];
      shadow1[hi[5:0]] = v[31:16];
    end
    if (rdo)
      md_model[sel] = {shadow1[hi[5:0]], shadow1[lo[5:0]]};
    push(0, 0, 0, 1, 1, 1, md_model[sel]);
    while (q.size() > 0) begin
      @(negedge clk);
      e = q.pop_front();
      o_fr = (sel == 1) ? fr1 : fr2;
      o_a  = (sel == 1) ? addr1 : addr2;
      o_d  = (sel == 1) ? dqo1 : dqo2;
      o_we = (sel == 1) ? we1 : we2;
      o_oe = (sel == 1) ? oe1 : oe2;
      o_md = (sel == 1) ? md1 : md2;
      chk({tag, ".freeze"}, 32'(o_fr), 32'(e.fr));
      chk({tag, ".addr"}, 32'(o_a), 32'(e.addr));
      chk({tag, ".dq"}, 32'(o_d), 32'(e.dq));
      chk({tag, ".we_n"}, 32'(o_we), 32'(e.we));
      chk({tag, ".oe_n"}, 32'(o_oe), 32'(e.oe));
      if (e.chk_md) chk({tag, ".mdata"}, o_md, e.md);
      @(posedge clk);
      #1;
    end
    rd1 = 0; wr1 = 0; rd2 = 0; wr2 = 0;
  endtask

  initial begin
    rst = 1; wb_en = 0; dest = 0;
    alu = 0; val = 0;
    rd1 = 0; wr1 = 0; rd2 = 0; wr2 = 0;
    md_model[0] = 0; md_model[1] = 0; md_model[2] = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;

    @(negedge clk);
    chk("reset.freeze", 32'(fr1), 0);
    chk("reset.mdata", md1, 0);
    chk("reset.addr", 32'(addr1), 0);
    chk("reset.dq", 32'(dqo1), 0);
    chk("reset.we_n", 32'(we1), 1);
    chk("reset.oe_n", 32'(oe1), 1);
    chk("reset.mdata2", md2, 0);
    @(posedge clk); #1;

    run_access(1, "store", 0, 1, 1028, 32'hDEADBEEF, 0);
    run_access(1, "load", 1, 0, 1028, 0, 0);

    wb_en = 1; dest = 4'hA; alu = 32'h55;
    @(negedge clk);
    chk("nomem.freeze", 32'(fr1), 0);
    chk("nomem.alu", alu_o1, 32'h55);
    chk("nomem.we_n", 32'(we1), 1);
    chk("nomem.oe_n", 32'(oe1), 1);
    chk("nomem.addr", 32'(addr1), 0);
    chk("nomem.wb", 32'(wb_o1), 1);
    chk("nomem.dest", 32'(dest_o1), 32'hA);
    chk("nomem.mread", 32'(mr_o1), 0);
    chk("nomem.md_hold", md1, 32'hDEADBEEF);
    @(posedge clk); #1;
    wb_en = 0; dest = 0;

    alu = 1028; rd1 = 1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk("rsthigh.addr", 32'(addr1), 3);
    chk("rsthigh.oe_n", 32'(oe1), 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    md_model[1] = 0;
    @(negedge clk);
    chk("rst.mdata", md1, 0);
    chk("rst.we_n", 32'(we1), 1);
    chk("rst.oe_n", 32'(oe1), 1);
    chk("rst.addr", 32'(addr1), 0);
    chk("rst.freeze", 32'(fr1), 1);
    @(posedge clk); #1;
    run_access(1, "restart", 1, 0, 1028, 0, 1);

    run_access(1, "rdwr", 1, 1, 1024, 32'h00010002, 0);
    chk("rdwr.sram0", 32'(mem1[0]), 32'h2);
    chk("rdwr.sram1", 32'(mem1[1]), 32'h1);

    run_access(2, "b2b0", 0, 1, 1024, 32'h11112222, 0);
    run_access(2, "b2b1", 0, 1, 1032, 32'h33334444, 0);
    chk("b2b.sram4", 32'(mem2[4]), 32'h4444);
    chk("b2b.sram5", 32'(mem2[5]), 32'h3333);
    run_access(2, "wrap", 0, 1, 1020, 32'hCAFEF00D, 0);
    chk("wrap.sram62", 32'(mem2[62]), 32'hF00D);
    chk("wrap.sram63", 32'(mem2[63]), 32'hCAFE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mem_stage_sram_ctrl.md
Name: mem_stage_sram_ctrl

Overview:
- Consumes the execute-stage results (ALU result as address, Rm value as store data, memory and writeback controls) and performs the data-memory access against an external 16-bit SRAM.
- Each 32-bit word is split into two 16-bit half accesses, low half first. Each half access has a configurable wait-state count.
- Asserts freeze back to the pipeline while an access is in flight.
- Presents load data and pass-through writeback controls to the MEM/WB register.

Parameters:
- WAIT_CYCLES, 2, cycles per 16-bit half access. Legal range 1..15.
- DATA_MEM_BASE, 1024, byte address mapped to SRAM word 0.
- SRAM_ADDR_LEN, 18, width of the SRAM half-word address.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  synchronous active-high reset
- wb_enable_in  in  1  writeback enable from the execute stage
- mem_read_in  in  1  load request
- mem_write_in  in  1  store request
- alu_res_in  in  32  byte address, or ALU result for non-memory ops
- val_rm_in  in  32  store data
- dest_in  in  4  destination register
- wb_enable_out  out  1  combinational pass of wb_enable_in
- mem_read_out  out  1  combinational pass of mem_read_in
- dest_out  out  4  combinational pass of dest_in
- alu_res_out  out  32  combinational pass of alu_res_in
- mem_data_out  out  32  registered load data
- freeze  out  1  stall request to IF/ID/EXE/pipeline registers
- sram_addr  out  18  SRAM half-word address
- sram_dq_out  out  16  SRAM write data
- sram_dq_in  in  16  SRAM read data
- sram_we_n  out  1  SRAM write strobe, active low
- sram_oe_n  out  1  SRAM output enable, active low

Behaviour:
- Address mapping:
  - word = (alu_res_in - DATA_MEM_BASE) >> 2, computed as 32-bit modular arithmetic.
  - sram_addr = {word[16:0], half}, where half=0 selects the low 16 bits and half=1 the high 16 bits.
  - Addresses below the base wrap. There is no error flag.
- FSM states: IDLE, LOW, HIGH, DONE. A 4-bit wait counter cnt is used in LOW and HIGH.
- Transitions:
  - IDLE: if mem_read_in or mem_write_in, go to LOW with cnt=0.
  - LOW: cnt increments each cycle. When cnt == WAIT_CYCLES-1, go to HIGH with cnt=0.
  - HIGH: same counting rule. When the count completes, go to DONE.
  - DONE: always go to IDLE after one cycle.
- freeze = (mem_read_in | mem_write_in) & (state != DONE). This is combinational.
  - For one access, freeze is high for 2*WAIT_CYCLES+1 cycles (the IDLE cycle plus the LOW and HIGH cycles), then low for exactly one cycle (DONE). The pipeline advances on that cycle.
- Store (mem_write_in=1):
  - LOW: sram_dq_out = val_rm_in[15:0], sram_we_n=0 for all cycles of the phase.
  - HIGH: sram_dq_out = val_rm_in[31:16], sram_we_n=0.
  - sram_oe_n=1 throughout.
  - mem_data_out is unchanged.
- Load (mem_read_in=1):
  - sram_oe_n=0 and sram_we_n=1 in LOW and HIGH.
  - sram_dq_in is sampled on the last cycle of LOW into mem_data_out[15:0], and on the last cycle of HIGH into mem_data_out[31:16].
  - mem_data_out is valid from DONE onward and holds its value until the next load completes.
- Idle drive: sram_we_n=1, sram_oe_n=1, sram_addr=0, sram_dq_out=0.
- Both mem_read_in and mem_write_in high: write wins. No read sample is taken.
- Request dropped mid-access (only possible on a flush): the FSM completes the current sequence, and freeze follows its equation.
- Back-to-back requests: after DONE the FSM returns to IDLE. The next request begins one cycle later, so at least one non-frozen cycle falls between accesses.
- Reset mid-operation:
  - Next edge: state=IDLE, cnt=0, mem_data_out=0, sram_we_n=1, sram_oe_n=1.
  - Any partially written word is left as-is in the SRAM.
- Reset values: mem_data_out=0, sram_addr=0, sram_dq_out=0, sram_we_n=1, sram_oe_n=1. freeze follows its combinational equation (state=IDLE).
- Non-memory ops: no SRAM activity, freeze=0, pass-through outputs only.

Decomposition:
- Shared package (defines.v):
  - REGISTER_LEN=32, ADDRESS_LEN=32, DATA_MEM_BASE=1024, SRAM_ADDR_LEN=18, SRAM_DATA_LEN=16.
  - Localparam state encodings: IDLE=2'd0, LOW=2'd1, HIGH=2'd2, DONE=2'd3.
- One sub-module: sram_wait_counter (clk, rst, clear, enable, terminal output at WAIT_CYCLES-1).

Test Plan:
- Store, WAIT_CYCLES=2: alu_res_in=1028, val_rm_in=0xDEADBEEF.
  - Expected: sram_addr=2 with dq=0xBEEF and we_n=0 for 2 cycles, then sram_addr=3 with dq=0xDEAD for 2 cycles.
  - freeze high 5 cycles, low on the 6th.
- Load after the store: alu_res_in=1028, bench SRAM model returns the stored halves.
  - Expected: mem_data_out=0xDEADBEEF in the DONE cycle, freeze profile identical to the store, we_n stays 1.
- Non-memory op: mem_read_in=mem_write_in=0, alu_res_in=0x55.
  - Expected: freeze=0, alu_res_out=0x55, we_n=oe_n=1, sram_addr=0.
- Reset in HIGH: assert rst during a load's HIGH phase.
  - Expected: next cycle state=IDLE, mem_data_out=0, we_n=oe_n=1.
  - After rst falls with the request still present, the access restarts at LOW.
- Read and write simultaneously, alu_res_in=1024, val_rm_in=0x00010002.
  - Expected: write performed (addr 0 gets 0x0002, addr 1 gets 0x0001), mem_data_out unchanged.
- WAIT_CYCLES=1, back-to-back stores to 1024 and 1032.
  - Expected: freeze high 3 cycles, low 1 cycle, high 3 cycles. sram_addr sequence 0,1 then 4,5.
